// File: rtl/miner_work_loader_if.sv
// Byte-stream valid/ready link between a host receiver (e.g. UART RX) and the work loader.
interface miner_work_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/miner_work_loader.sv
// Framed work receiver: sync byte, header+target payload, XOR checksum.
// A good frame updates header/target with a one-cycle work_load strobe; bad or
// stalled frames raise err and leave the live work untouched.
module miner_work_loader #(
    parameter int unsigned HEADER_W       = 608,
    parameter int unsigned TARGET_W       = 256,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                 osc_clk,
    input  logic                 rst_n,
    miner_work_loader_if.slave   bus,
    output logic [HEADER_W-1:0]  header,
    output logic [TARGET_W-1:0]  target,
    output logic                 work_load,
    output logic [CNT_W-1:0]     work_count,
    output logic                 err,
    output logic [1:0]           err_code
);
    localparam int unsigned PAYLOAD_W = HEADER_W + TARGET_W;
    localparam int unsigned P_BYTES   = PAYLOAD_W / 8;
    localparam int unsigned BCNT_W    = $clog2(P_BYTES + 1);
    localparam int unsigned GAP_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_COMMIT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PAYLOAD_W-1:0]  r_shift;
    logic [7:0]            r_csum;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [GAP_W-1:0]      r_gap;
    logic [HEADER_W-1:0]   r_header;
    logic [TARGET_W-1:0]   r_target;
    logic [CNT_W-1:0]      r_work_count;
    logic                  r_work_load;
    logic                  r_err;
    logic [1:0]            r_err_code;
    logic                  r_in_ready;

    logic                  w_accept;
    logic                  w_sync;
    logic                  w_in_frame;
    logic                  w_timeout;
    logic                  w_last;
    logic                  w_csum_ok;
    logic                  w_commit;
    logic                  w_load_nxt;
    logic                  w_err_nxt;
    logic [1:0]            w_err_code_nxt;
    logic                  w_ready_nxt;

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_sync     = (bus.in_data == SYNC_BYTE);
    assign w_in_frame = (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    assign w_timeout  = w_in_frame && !w_accept && (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));
    assign w_last     = (r_bcnt == BCNT_W'(P_BYTES - 1));
    assign w_csum_ok  = (bus.in_data == r_csum);

    assign bus.in_ready = r_in_ready;
    assign header       = r_header;
    assign target       = r_target;
    assign work_load    = r_work_load;
    assign work_count   = r_work_count;
    assign err          = r_err;
    assign err_code     = r_err_code;

    // State register
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; a timeout or any checksum outcome always ends the frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_sync) w_state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (w_accept) begin
                    if (w_last) w_state_nxt = S_CHECK;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                if (w_accept)       w_state_nxt = w_csum_ok ? S_COMMIT : S_IDLE;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes, ready and error code
    always_comb begin
        w_commit       = 1'b0;
        w_load_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = r_err_code;
        w_ready_nxt    = 1'b1;
        case (r_state)
            S_PAYLOAD: begin
                if (w_timeout) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = 2'b10;
                end
            end
            S_CHECK: begin
                if (w_accept && w_csum_ok) begin
                    w_commit    = 1'b1;
                    w_load_nxt  = 1'b1;
                    w_ready_nxt = 1'b0;
                end else if (w_accept) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = 2'b01;
                end else if (w_timeout) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = 2'b10;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and committed work
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b1;
            r_work_load  <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'b00;
            r_header     <= '0;
            r_target     <= '0;
            r_work_count <= '0;
        end else begin
            r_in_ready  <= w_ready_nxt;
            r_work_load <= w_load_nxt;
            r_err       <= w_err_nxt;
            r_err_code  <= w_err_code_nxt;
            if (w_commit) begin
                r_header     <= r_shift[PAYLOAD_W-1 -: HEADER_W];
                r_target     <= r_shift[TARGET_W-1:0];
                r_work_count <= r_work_count + CNT_W'(1);
            end
        end
    end

    // Payload shift register, running checksum, byte counter and inter-byte gap counter
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_csum  <= '0;
            r_bcnt  <= '0;
            r_gap   <= '0;
        end else begin
            if (r_state == S_IDLE && w_accept && w_sync) begin
                r_csum <= '0;
                r_bcnt <= '0;
            end else if (r_state == S_PAYLOAD && w_accept) begin
                r_shift <= {r_shift[PAYLOAD_W-9:0], bus.in_data};
                r_csum  <= r_csum ^ bus.in_data;
                r_bcnt  <= r_bcnt + BCNT_W'(1);
            end
            if (w_in_frame && !w_accept && !w_timeout) r_gap <= r_gap + GAP_W'(1);
            else                                       r_gap <= '0;
        end
    end
endmodule

// File: tb/tb_miner_work_loader.sv
module tb_miner_work_loader;
    localparam int unsigned HEADER_W = 608;
    localparam int unsigned TARGET_W = 256;
    localparam int unsigned CW       = HEADER_W;
    localparam int unsigned P        = (HEADER_W + TARGET_W) / 8;
    localparam int unsigned HB       = HEADER_W / 8;
    localparam int unsigned TO       = 1500;
    localparam logic [7:0]  SYNC     = 8'hA5;

    logic                osc_clk = 1'b0;
    logic                rst_n   = 1'b0;
    logic [HEADER_W-1:0] header;
    logic [TARGET_W-1:0] target;
    logic                work_load;
    logic [7:0]          work_count;
    logic                err;
    logic [1:0]          err_code;

    miner_work_loader_if bus ();

    miner_work_loader #(
        .HEADER_W(HEADER_W), .TARGET_W(TARGET_W), .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(TO), .CNT_W(8)
    ) dut (
        .osc_clk(osc_clk), .rst_n(rst_n), .bus(bus),
        .header(header), .target(target), .work_load(work_load),
        .work_count(work_count), .err(err), .err_code(err_code)
    );

    always #5 osc_clk = ~osc_clk;

    typedef struct {
        logic                is_err;
        logic [1:0]          code;
        logic [HEADER_W-1:0] hdr;
        logic [TARGET_W-1:0] tgt;
        logic [7:0]          cnt;
    } exp_t;

    exp_t                sb[$];
    int                  checks  = 0;
    int                  errors  = 0;
    int                  n_loads = 0;
    logic [7:0]          pl [P];
    logic [HEADER_W-1:0] m_hdr = '0;
    logic [TARGET_W-1:0] m_tgt = '0;
    logic [7:0]          m_cnt = '0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a good frame's payload bytes are laid out MSB-first across header then target
    task automatic push_load();
        exp_t e;
        for (int i = 0; i < int'(P); i++) begin
            if (i < int'(HB)) m_hdr[HEADER_W-1-8*i -: 8] = pl[i];
            else              m_tgt[TARGET_W-1-8*(i-int'(HB)) -: 8] = pl[i];
        end
        m_cnt    = m_cnt + 8'd1;
        e.is_err = 1'b0;
        e.code   = 2'b00;
        e.hdr    = m_hdr;
        e.tgt    = m_tgt;
        e.cnt    = m_cnt;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1;
        e.code   = code;
        e.hdr    = m_hdr;
        e.tgt    = m_tgt;
        e.cnt    = m_cnt;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge osc_clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 8) begin
            @(negedge osc_clk);
            n++;
        end
        chk("ready_wait", CW'(bus.in_ready), CW'(1));
    endtask

    task automatic idle(input int n);
        @(negedge osc_clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat (n - 1) @(negedge osc_clk);
    endtask

    task automatic send_frame(input logic [7:0] flip, input bit gappy);
        logic [7:0] cs;
        cs = 8'h00;
        send_byte(SYNC);
        for (int i = 0; i < int'(P); i++) begin
            if (gappy && $urandom_range(3) == 0) idle(int'($urandom_range(3, 1)));
            send_byte(pl[i]);
            cs = cs ^ pl[i];
        end
        if (flip != 8'h00) push_err(2'b01);
        else               push_load();
        send_byte(cs ^ flip);
    endtask

    task automatic fill_t1();
        for (int i = 0; i < int'(P); i++) pl[i] = (i < 76) ? 8'hAA : 8'hFF;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < int'(P); i++) begin
            pl[i] = 8'($urandom);
            if ($urandom_range(15) == 0) pl[i] = SYNC;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge osc_clk);
            n++;
        end
        chk(name, CW'(sb.size()), CW'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_header"},     CW'(header),       CW'(0));
        chk({tag, "_target"},     CW'(target),       CW'(0));
        chk({tag, "_work_load"},  CW'(work_load),    CW'(0));
        chk({tag, "_work_count"}, CW'(work_count),   CW'(0));
        chk({tag, "_err"},        CW'(err),          CW'(0));
        chk({tag, "_err_code"},   CW'(err_code),     CW'(0));
        chk({tag, "_in_ready"},   CW'(bus.in_ready), CW'(1));
    endtask

    // Monitor: pops one expectation per load/err strobe and checks strobe widths
    logic prev_load = 1'b0;
    logic prev_err  = 1'b0;
    always @(negedge osc_clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_load = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (prev_load) begin
                chk("load_one_cycle", CW'(work_load), CW'(0));
                chk("ready_back_high", CW'(bus.in_ready), CW'(1));
            end
            if (prev_err) chk("err_one_cycle", CW'(err), CW'(0));
            if (work_load || err) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event load=%0b err=%0b code=%0b", work_load, err, err_code);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_err", CW'(err), CW'(e.is_err));
                    chk("event_kind_load", CW'(work_load), CW'(!e.is_err));
                    chk("header", CW'(header), CW'(e.hdr));
                    chk("target", CW'(target), CW'(e.tgt));
                    chk("work_count", CW'(work_count), CW'(e.cnt));
                    if (e.is_err) chk("err_code", CW'(err_code), CW'(e.code));
                    else          chk("ready_low_in_commit", CW'(bus.in_ready), CW'(0));
                end
            end
            if (work_load) n_loads++;
            prev_load = work_load;
            prev_err  = err;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b0;
        repeat (3) @(negedge osc_clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge osc_clk);

        // T1 good frame
        fill_t1();
        send_frame(8'h00, 1'b0);
        idle(3);

        // T2 bad checksum
        send_frame(8'h01, 1'b0);
        idle(3);
        chk("t2_err_code_held", CW'(err_code), CW'(2'b01));

        // T3 stall mid-frame
        send_byte(SYNC);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        push_err(2'b10);
        idle(int'(TO) + 3);
        chk("t3_err_code_held", CW'(err_code), CW'(2'b10));
        fill_t1();
        send_frame(8'h00, 1'b0);
        idle(2);

        // T4 junk before sync, sync value inside payload
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        fill_t1();
        pl[5]  = SYNC;
        pl[90] = SYNC;
        send_frame(8'h00, 1'b0);
        idle(2);
        drain("drain_before_t5");

        // T5 asynchronous reset mid-frame
        fill_rand();
        send_byte(SYNC);
        for (int i = 0; i < 50; i++) send_byte(pl[i]);
        @(posedge osc_clk);
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk_reset_vals("t5_reset");
        chk("t5_no_pending", CW'(sb.size()), CW'(0));
        m_hdr = '0;
        m_tgt = '0;
        m_cnt = '0;
        repeat (2) @(negedge osc_clk);
        rst_n = 1'b1;
        fill_t1();
        send_frame(8'h00, 1'b0);
        idle(2);
        chk("t5_count_after", CW'(work_count), CW'(1));

        // Randomized frames with junk, gaps and corrupted checksums
        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < int'($urandom_range(2)); j++) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                send_byte(b);
            end
            fill_rand();
            if ($urandom_range(4) == 0) send_frame(8'(1 << $urandom_range(7)), 1'b1);
            else                        send_frame(8'h00, 1'b1);
            if ($urandom_range(1) == 0) idle(int'($urandom_range(4, 1)));
        end
        idle(2);
        drain("drain_before_t6");

        // T6 256 back-to-back frames, counter wrap
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        m_hdr        = '0;
        m_tgt        = '0;
        m_cnt        = '0;
        repeat (2) @(negedge osc_clk);
        rst_n   = 1'b1;
        n_loads = 0;
        for (int k = 0; k < 256; k++) begin
            fill_rand();
            send_frame(8'h00, 1'b0);
        end
        idle(5);
        drain("drain_end");
        chk("t6_load_pulses", CW'(n_loads), CW'(256));
        chk("t6_count_wrapped", CW'(work_count), CW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
